// File: rtl/mips32_mem_responder_if.sv
// Request/response bundle between the MIPS pipeline (master) and mips32_mem_responder (slave).
// Handshake: a request is accepted on a rising edge where valid && ready; the requester keeps valid and its fields stable until then. Responses are single-cycle rsp_valid pulses and are never back-pressured.
interface mips32_mem_responder_if #(
  parameter int ADDR_W = 32
) ();
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_data;
  logic              if_rsp_err;

  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_we;
  logic [ADDR_W-1:0] d_req_addr;
  logic [31:0]       d_req_wdata;
  logic              d_rsp_valid;
  logic [31:0]       d_rsp_data;
  logic              d_rsp_err;

  modport master (
    output if_req_valid, if_req_addr,
    output d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    input  if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );

  modport slave (
    input  if_req_valid, if_req_addr,
    input  d_req_valid, d_req_we, d_req_addr, d_req_wdata,
    output if_req_ready, if_rsp_valid, if_rsp_data, if_rsp_err,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err
  );
endinterface

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory serving fetch and data ports, one transaction outstanding, programmable latency.
// Optional MEM_RESP_RR_ARB_EN: round-robin arbitration instead of fixed data-over-fetch priority.
module mips32_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  mips32_mem_responder_if.slave  bus,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]      WAIT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W + 1)'(DEPTH);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              own_d_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              d_acc, f_acc;
  logic              in_range;
  logic              commit;
  logic [31:0]       rd_word;
  logic [31:0]       mem [DEPTH];

`ifdef MEM_RESP_RR_ARB_EN
  logic rr_q;  // 1 = data port preferred on conflict
`endif

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bus.d_req_ready  = 1'b0;
    bus.if_req_ready = 1'b0;
    d_acc            = 1'b0;
    f_acc            = 1'b0;
    case (state_q)
      S_IDLE: begin
`ifdef MEM_RESP_RR_ARB_EN
        bus.d_req_ready  = !bus.if_req_valid || rr_q;
        bus.if_req_ready = !bus.d_req_valid || !rr_q;
`else
        bus.d_req_ready  = 1'b1;
        bus.if_req_ready = !bus.d_req_valid;
`endif
        d_acc = bus.d_req_valid && bus.d_req_ready;
        f_acc = bus.if_req_valid && bus.if_req_ready;
        if (d_acc || f_acc) begin
          // WAIT covers LATENCY-1 cycles; RESP is the cycle ending on the access edge
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Full-width compare so out-of-range addresses never alias onto the array
  assign in_range  = {1'b0, addr_q} < DEPTH_X;
  assign commit    = (state_q == S_RESP) && we_q && in_range;
  assign rd_word   = mem[addr_q[IDX_W-1:0]];
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_data  <= 32'd0;
      bus.if_rsp_err   <= 1'b0;
      bus.d_rsp_valid  <= 1'b0;
      bus.d_rsp_data   <= 32'd0;
      bus.d_rsp_err    <= 1'b0;
`ifdef MEM_RESP_RR_ARB_EN
      rr_q             <= 1'b1;
`endif
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      bus.if_rsp_valid <= 1'b0;
      bus.if_rsp_data  <= 32'd0;
      bus.if_rsp_err   <= 1'b0;
      bus.d_rsp_valid  <= 1'b0;
      bus.d_rsp_data   <= 32'd0;
      bus.d_rsp_err    <= 1'b0;
      if (d_acc) begin
        own_d_q <= 1'b1;
        we_q    <= bus.d_req_we;
        addr_q  <= bus.d_req_addr;
        wdata_q <= bus.d_req_wdata;
      end else if (f_acc) begin
        own_d_q <= 1'b0;
        we_q    <= 1'b0;
        addr_q  <= bus.if_req_addr;
        wdata_q <= 32'd0;
      end
`ifdef MEM_RESP_RR_ARB_EN
      if (d_acc)      rr_q <= 1'b0;
      else if (f_acc) rr_q <= 1'b1;
`endif
      if (state_q == S_RESP) begin
        if (own_d_q) begin
          bus.d_rsp_valid <= 1'b1;
          bus.d_rsp_err   <= !in_range;
          bus.d_rsp_data  <= (in_range && !we_q) ? rd_word : 32'd0;
        end else begin
          bus.if_rsp_valid <= 1'b1;
          bus.if_rsp_err   <= !in_range;
          bus.if_rsp_data  <= in_range ? rd_word : 32'd0;
        end
      end
    end
  end

  // Array is never reset; a store reaching its access edge during reset is discarded
  always_ff @(posedge clk) begin
    if (commit && !reset) mem[addr_q[IDX_W-1:0]] <= wdata_q;
  end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench for mips32_mem_responder: LATENCY=2 instance for function/arbitration/reset, LATENCY=1 instance for back-to-back.
module tb_mips32_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy_a, busy_b;
  logic [1:0] dbg_a, dbg_b;
  int         errors = 0;
  int         checks = 0;
  logic [31:0] exp_q[$];

  mips32_mem_responder_if #(.ADDR_W(32)) bus_a ();
  mips32_mem_responder_if #(.ADDR_W(32)) bus_b ();

  mips32_mem_responder #(.DEPTH(1024), .ADDR_W(32), .LATENCY(2)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .busy(busy_a), .dbg_state(dbg_a)
  );

  mips32_mem_responder #(.DEPTH(1024), .ADDR_W(32), .LATENCY(1)) u_dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .busy(busy_b), .dbg_state(dbg_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction on instance A; returns at the negedge where the response is visible
  task automatic txn_a(input bit is_d, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    int n;
    @(posedge clk); #1;
    if (is_d) begin
      bus_a.d_req_valid = 1'b1;
      bus_a.d_req_we    = we;
      bus_a.d_req_addr  = addr;
      bus_a.d_req_wdata = wdata;
    end else begin
      bus_a.if_req_valid = 1'b1;
      bus_a.if_req_addr  = addr;
    end
    @(negedge clk);
    n = 0;
    while (!(is_d ? bus_a.d_req_ready : bus_a.if_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n >= 50), 32'd0);
    @(posedge clk); #1;
    bus_a.d_req_valid  = 1'b0;
    bus_a.if_req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_d ? bus_a.d_rsp_valid : bus_a.if_rsp_valid) && n < 50);
    check("rsp_timeout", 32'(n >= 50), 32'd0);
    check("rsp_other_quiet", is_d ? bus_a.if_rsp_valid : bus_a.d_rsp_valid, 32'd0);
    rdata = is_d ? bus_a.d_rsp_data : bus_a.if_rsp_data;
    err   = is_d ? bus_a.d_rsp_err  : bus_a.if_rsp_err;
    lat   = n - 1;
  endtask

  task automatic store_b(input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    @(posedge clk); #1;
    bus_b.d_req_valid = 1'b1;
    bus_b.d_req_we    = 1'b1;
    bus_b.d_req_addr  = addr;
    bus_b.d_req_wdata = wdata;
    @(negedge clk);
    n = 0;
    while (!bus_b.d_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    bus_b.d_req_valid = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus_b.d_rsp_valid && n < 100);
    check("b_store_err", bus_b.d_rsp_err, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;
    bit          got_d;
    bit          exp_seq[3];
    logic [31:0] vals_b[3];
    logic        seen;

    reset = 1'b1;
    bus_a.if_req_valid = 1'b0; bus_a.if_req_addr = '0;
    bus_a.d_req_valid = 1'b0; bus_a.d_req_we = 1'b0; bus_a.d_req_addr = '0; bus_a.d_req_wdata = '0;
    bus_b.if_req_valid = 1'b0; bus_b.if_req_addr = '0;
    bus_b.d_req_valid = 1'b0; bus_b.d_req_we = 1'b0; bus_b.d_req_addr = '0; bus_b.d_req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", busy_a, 32'd0);
    check("rst_if_rsp_valid", bus_a.if_rsp_valid, 32'd0);
    check("rst_d_rsp_valid", bus_a.d_rsp_valid, 32'd0);
    check("rst_d_rsp_data", bus_a.d_rsp_data, 32'd0);
    check("rst_if_ready", bus_a.if_req_ready, 32'd1);
    check("rst_d_ready", bus_a.d_req_ready, 32'd1);

    // Preload and store/load round trip
    txn_a(1'b1, 1'b1, 32'd5, 32'h2842000A, rd, er, lat);
    check("st5_data", rd, 32'd0);
    check("st5_err", er, 32'd0);
    check("st5_lat", lat, 32'd2);
    txn_a(1'b1, 1'b1, 32'd7, 32'hDEADBEEF, rd, er, lat);
    check("st7_data", rd, 32'd0);
    check("st7_err", er, 32'd0);
    txn_a(1'b1, 1'b0, 32'd7, 32'd0, rd, er, lat);
    check("ld7_data", rd, 32'hDEADBEEF);
    check("ld7_err", er, 32'd0);
    check("ld7_lat", lat, 32'd2);

    txn_a(1'b0, 1'b0, 32'd5, 32'd0, rd, er, lat);
    check("f5_data", rd, 32'h2842000A);
    check("f5_err", er, 32'd0);
    check("f5_lat", lat, 32'd2);
    @(negedge clk);
    check("f5_pulse_one_cycle", bus_a.if_rsp_valid, 32'd0);
    check("f5_ready_again", bus_a.if_req_ready, 32'd1);

    // Conflict: both ports request together
`ifdef MEM_RESP_RR_ARB_EN
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b1;
`else
    exp_seq[0] = 1'b1; exp_seq[1] = 1'b0; exp_seq[2] = 1'b0;
`endif
    @(posedge clk); #1;
    bus_a.d_req_valid  = 1'b1; bus_a.d_req_we = 1'b0; bus_a.d_req_addr = 32'd7;
    bus_a.if_req_valid = 1'b1; bus_a.if_req_addr = 32'd5;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!((bus_a.d_req_valid && bus_a.d_req_ready) ||
               (bus_a.if_req_valid && bus_a.if_req_ready)) && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("arb_timeout", 32'(n >= 50), 32'd0);
      got_d = bus_a.d_req_valid && bus_a.d_req_ready;
      check($sformatf("arb_order%0d", k), got_d, exp_seq[k]);
      @(posedge clk); #1;
`ifndef MEM_RESP_RR_ARB_EN
      if (got_d) bus_a.d_req_valid = 1'b0;
`endif
      if (k == 2) begin
        bus_a.d_req_valid  = 1'b0;
        bus_a.if_req_valid = 1'b0;
      end
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(got_d ? bus_a.d_rsp_valid : bus_a.if_rsp_valid) && n < 50);
      if (got_d) check($sformatf("arb_ld%0d", k), bus_a.d_rsp_data, 32'hDEADBEEF);
      else       check($sformatf("arb_f%0d", k), bus_a.if_rsp_data, 32'h2842000A);
    end

    // Range checks
    txn_a(1'b1, 1'b0, 32'd1024, 32'd0, rd, er, lat);
    check("ld1024_data", rd, 32'd0);
    check("ld1024_err", er, 32'd1);
    txn_a(1'b1, 1'b1, 32'd1023, 32'h12345678, rd, er, lat);
    check("st1023_err", er, 32'd0);
    txn_a(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hCAFEF00D, rd, er, lat);
    check("st_ffff_err", er, 32'd1);
    check("st_ffff_data", rd, 32'd0);
    txn_a(1'b1, 1'b0, 32'd1023, 32'd0, rd, er, lat);
    check("ld1023_kept", rd, 32'h12345678);
    txn_a(1'b0, 1'b0, 32'd2000, 32'd0, rd, er, lat);
    check("f2000_err", er, 32'd1);
    check("f2000_data", rd, 32'd0);
    txn_a(1'b1, 1'b1, 32'd3, 32'h00000055, rd, er, lat);
    txn_a(1'b1, 1'b1, 32'h0001_0003, 32'h00000BAD, rd, er, lat);
    check("st_alias_err", er, 32'd1);
    txn_a(1'b1, 1'b0, 32'd3, 32'd0, rd, er, lat);
    check("ld3_no_alias", rd, 32'h00000055);

    // Reset during an outstanding store
    @(posedge clk); #1;
    bus_a.d_req_valid = 1'b1; bus_a.d_req_we = 1'b1;
    bus_a.d_req_addr = 32'd3; bus_a.d_req_wdata = 32'h1;
    @(negedge clk);
    check("abort_ready", bus_a.d_req_ready, 32'd1);
    @(posedge clk); #1;
    bus_a.d_req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy_a, 32'd0);
    check("abort_if_ready", bus_a.if_req_ready, 32'd1);
    check("abort_d_ready", bus_a.d_req_ready, 32'd1);
    seen = bus_a.d_rsp_valid;
    repeat (4) begin
      @(negedge clk);
      seen = seen | bus_a.d_rsp_valid;
    end
    check("abort_no_rsp", seen, 32'd0);
    txn_a(1'b1, 1'b0, 32'd3, 32'd0, rd, er, lat);
    check("abort_mem3_kept", rd, 32'h00000055);

    // LATENCY=1 back-to-back fetches
    vals_b[0] = 32'h11111111; vals_b[1] = 32'h22222222; vals_b[2] = 32'h33333333;
    for (int i = 0; i < 3; i++) store_b(32'(i), vals_b[i]);
    @(posedge clk); #1;
    bus_b.if_req_valid = 1'b1;
    bus_b.if_req_addr  = 32'd0;
    for (int i = 0; i < 3; i++) exp_q.push_back(vals_b[i]);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("b2b_ready%0d", i), bus_b.if_req_ready, 32'd1);
      @(posedge clk); #1;
      if (i < 2) bus_b.if_req_addr = 32'(i + 1);
      else       bus_b.if_req_valid = 1'b0;
      @(negedge clk);
      check($sformatf("b2b_gap%0d", i), bus_b.if_rsp_valid, 32'd0);
      check($sformatf("b2b_busy%0d", i), busy_b, 32'd1);
      @(negedge clk);
      check($sformatf("b2b_rsp%0d", i), bus_b.if_rsp_valid, 32'd1);
      if (exp_q.size() > 0) check($sformatf("b2b_data%0d", i), bus_b.if_rsp_data, exp_q.pop_front());
      else                  check($sformatf("b2b_underflow%0d", i), 32'd1, 32'd0);
    end
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
